subservient_sram_arb: RTL and testbench
=======================================

SUBSERVIENT_SRAM_ARB -- requirements
Module: subservient_sram_arb

Interface
REQ-001 Parameter memsize, default 512: SRAM depth in bytes.
REQ-002 Parameter aw, default $clog2(memsize): SRAM address width.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_p0_req  input  1  port 0 (loader/debug) access request.
REQ-006 i_p0_we  input  1  port 0 write (1) / read (0) select.
REQ-007 i_p0_addr  input  aw  port 0 byte address.
REQ-008 i_p0_wdata  input  8  port 0 write data.
REQ-009 o_p0_gnt  output  1  port 0 access accepted this cycle.
REQ-010 o_p0_rvalid  output  1  port 0 read data valid.
REQ-011 o_p0_rdata  output  8  port 0 read data.
REQ-012 i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, o_p1_gnt, o_p1_rvalid, o_p1_rdata: port 1 (CPU), same directions and widths as port 0.
REQ-013 o_sram_waddr  output  aw  SRAM write address.
REQ-014 o_sram_wdata  output  8  SRAM write data.
REQ-015 o_sram_wen  output  1  SRAM write enable.
REQ-016 o_sram_raddr  output  aw  SRAM read address.
REQ-017 i_sram_rdata  input  8  SRAM read data, valid one cycle after raddr presented.

Function
REQ-018 At most one port granted per cycle; o_pN_gnt combinational from requests and arbitration pointer, asserted only when i_pN_req=1.
REQ-019 Single requester: granted same cycle, no bubble.
REQ-020 Both requesting: grant goes to the port not granted most recently (round-robin); 1-bit pointer last_gnt updates only on a grant cycle.
REQ-021 Granted port drives o_sram_waddr, o_sram_raddr (both = granted addr) and o_sram_wdata; o_sram_wen = granted port's we.
REQ-022 No grant: o_sram_wen=0; addresses/wdata driven from port 1 inputs.
REQ-023 Accepted read: registered tag asserts o_pN_rvalid exactly one cycle after grant, for one cycle; o_pN_rdata = i_sram_rdata (both ports see same data; only rvalid qualifies).
REQ-024 Accepted write: no rvalid; memory updated at grant-cycle edge.
REQ-025 Back-to-back reads from same port: one per cycle, rvalid stays high continuously.
REQ-026 Requests may drop without grant; no request is queued internally.
REQ-027 Write then read same address on consecutive cycles returns written data (SRAM write-before-next-read ordering).

Reset
REQ-028 i_rst_n low: last_gnt=1 (port 0 wins first tie), both rvalid tags=0, asynchronously.
REQ-029 Reset mid-read: pending rvalid dropped; no rvalid after reset release.
REQ-030 During reset o_pN_gnt=0 and o_sram_wen=0.

Configuration
REQ-031 Macro SUBSERVIENT_SRAM_ARB_STATS_EN defined: adds output o_conflicts [15:0], counts cycles with both requests high, saturates at 16'hFFFF, reset to 0.
REQ-032 Macro undefined: o_conflicts port and counter absent; arbitration behaviour identical.

Verification
REQ-033 Port 0 write 0xA5 to addr 0x010, then port 0 read 0x010 -> gnt both cycles, rvalid next cycle with rdata=0xA5.
REQ-034 Both ports read continuously for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1; each rvalid one cycle after own grant.
REQ-035 Port 1 alone reads 0x000..0x003 back-to-back -> 4 consecutive gnt, 4 consecutive rvalid, data matches preload.
REQ-036 Port 0 write 0x3C while port 1 requests read, same cycle after p0 last granted -> p1 granted, o_sram_wen=0; p0 granted next cycle, o_sram_wen=1.
REQ-037 Assert i_rst_n low the cycle after a p1 read grant -> o_p1_rvalid=0 through and after reset; next tie goes to p0.
REQ-038 With SUBSERVIENT_SRAM_ARB_STATS_EN: 10 contention cycles -> o_conflicts=10; force 70000 contention cycles -> o_conflicts=16'hFFFF.

Source files
------------

// File: rtl/subservient_sram_arb.sv
// ============================================================================
// Module   : subservient_sram_arb
// Purpose  : Two-port round-robin arbiter in front of a single-port byte SRAM.
//            Optional conflict counter enabled by SUBSERVIENT_SRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subservient_sram_arb #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [aw-1:0] i_p0_addr,
  input  logic [7:0]    i_p0_wdata,
  output logic          o_p0_gnt,
  output logic          o_p0_rvalid,
  output logic [7:0]    o_p0_rdata,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [aw-1:0] i_p1_addr,
  input  logic [7:0]    i_p1_wdata,
  output logic          o_p1_gnt,
  output logic          o_p1_rvalid,
  output logic [7:0]    o_p1_rdata,
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  output logic [15:0]   o_conflicts,
`endif
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata
);

  // r_last_gnt = 1 means port 1 was granted most recently, so port 0 wins a tie
  logic    r_last_gnt;
  logic    r_p0_rvalid;
  logic    r_p1_rvalid;
  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_both;
  logic [aw-1:0] w_addr;

  assign w_both = i_p0_req & i_p1_req;
  assign w_gnt0 = i_rst_n & i_p0_req & (~i_p1_req | r_last_gnt);
  assign w_gnt1 = i_rst_n & i_p1_req & (~i_p0_req | ~r_last_gnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_gnt  <= 1'b1;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      if (w_gnt0)
        r_last_gnt <= 1'b0;
      else if (w_gnt1)
        r_last_gnt <= 1'b1;
      r_p0_rvalid <= w_gnt0 & ~i_p0_we;
      r_p1_rvalid <= w_gnt1 & ~i_p1_we;
    end
  end

  // Port 1 owns the SRAM bus whenever port 0 is not granted
  assign w_addr       = w_gnt0 ? i_p0_addr : i_p1_addr;
  assign o_sram_waddr = w_addr;
  assign o_sram_raddr = w_addr;
  assign o_sram_wdata = w_gnt0 ? i_p0_wdata : i_p1_wdata;
  assign o_sram_wen   = (w_gnt0 & i_p0_we) | (w_gnt1 & i_p1_we);

  assign o_p0_gnt    = w_gnt0;
  assign o_p1_gnt    = w_gnt1;
  assign o_p0_rvalid = r_p0_rvalid;
  assign o_p1_rvalid = r_p1_rvalid;
  assign o_p0_rdata  = i_sram_rdata;
  assign o_p1_rdata  = i_sram_rdata;

`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  logic [15:0] r_conflicts;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_conflicts <= 16'd0;
    else if (w_both && (r_conflicts != 16'hFFFF))
      r_conflicts <= r_conflicts + 16'd1;
  end

  assign o_conflicts = r_conflicts;
`else
  logic w_unused;
  assign w_unused = w_both;
`endif

endmodule

`default_nettype wire

// File: tb/tb_subservient_sram_arb.sv
// ============================================================================
// Module   : tb_subservient_sram_arb
// Purpose  : Directed self-checking bench for subservient_sram_arb with a
//            behavioural SRAM. Stats checks compiled in with
//            SUBSERVIENT_SRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subservient_sram_arb;

  logic       clk;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [8:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [8:0] sram_waddr, sram_raddr;
  logic [7:0] sram_wdata, sram_rdata;
  logic       sram_wen;
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  logic [15:0] conflicts;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:511];

  subservient_sram_arb #(.memsize(512)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_p0_req     (p0_req),
    .i_p0_we      (p0_we),
    .i_p0_addr    (p0_addr),
    .i_p0_wdata   (p0_wdata),
    .o_p0_gnt     (p0_gnt),
    .o_p0_rvalid  (p0_rvalid),
    .o_p0_rdata   (p0_rdata),
    .i_p1_req     (p1_req),
    .i_p1_we      (p1_we),
    .i_p1_addr    (p1_addr),
    .i_p1_wdata   (p1_wdata),
    .o_p1_gnt     (p1_gnt),
    .o_p1_rvalid  (p1_rvalid),
    .o_p1_rdata   (p1_rdata),
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    .o_conflicts  (conflicts),
`endif
    .o_sram_waddr (sram_waddr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wen   (sram_wen),
    .o_sram_raddr (sram_raddr),
    .i_sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: write lands at the edge, read data one cycle after raddr
  always @(posedge clk) begin
    if (sram_wen) mem[sram_waddr] <= sram_wdata;
    sram_rdata <= mem[sram_raddr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply a request pattern mid-cycle and settle before sampling
  task automatic drive(input logic r0, input logic w0, input logic [8:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [8:0] a1, input logic [7:0] d1);
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

    // Outputs held quiet while in reset, even with both ports requesting
    drive(1'b1, 1'b1, 9'h001, 8'h11, 1'b1, 1'b1, 9'h002, 8'h22);
    chk("rst_gnt0", 16'(p0_gnt), 16'h0);
    chk("rst_gnt1", 16'(p1_gnt), 16'h0);
    chk("rst_wen", 16'(sram_wen), 16'h0);
    chk("rst_rv0", 16'(p0_rvalid), 16'h0);
    chk("rst_rv1", 16'(p1_rvalid), 16'h0);
    idle();
    rst_n = 1'b1;
    idle();

    // Preload 0x000..0x003 with C0..C3 via port 0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 9'(i), 8'hC0 + 8'(i), 1'b0, 1'b0, 9'h000, 8'h00);
      chk("pre_gnt0", 16'(p0_gnt), 16'h1);
      chk("pre_wen", 16'(sram_wen), 16'h1);
    end

    // Port 0 write A5 to 0x010, then read it back
    drive(1'b1, 1'b1, 9'h010, 8'hA5, 1'b0, 1'b0, 9'h000, 8'h00);
    chk("wr_gnt0", 16'(p0_gnt), 16'h1);
    chk("wr_waddr", 16'(sram_waddr), 16'h010);
    chk("wr_wdata", 16'(sram_wdata), 16'h0A5);
    drive(1'b1, 1'b0, 9'h010, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    chk("rd_gnt0", 16'(p0_gnt), 16'h1);
    chk("rd_wen", 16'(sram_wen), 16'h0);
    chk("wr_no_rv0", 16'(p0_rvalid), 16'h0);
    idle();
    chk("rd_rv0", 16'(p0_rvalid), 16'h1);
    chk("rd_rv1", 16'(p1_rvalid), 16'h0);
    chk("rd_data", 16'(p0_rdata), 16'h0A5);

    // Fresh reset: contention alternates starting with port 0
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 9'h010, 8'h00, 1'b1, 1'b0, 9'h000, 8'h00);
      chk("rr_gnt0", 16'(p0_gnt), (k % 2 == 0) ? 16'h1 : 16'h0);
      chk("rr_gnt1", 16'(p1_gnt), (k % 2 == 1) ? 16'h1 : 16'h0);
      if (k > 0) begin
        chk("rr_rv0", 16'(p0_rvalid), (k % 2 == 1) ? 16'h1 : 16'h0);
        chk("rr_rv1", 16'(p1_rvalid), (k % 2 == 0) ? 16'h1 : 16'h0);
        chk("rr_data", 16'(p0_rdata), (k % 2 == 1) ? 16'h0A5 : 16'h0C0);
      end
    end
    idle();
    chk("rr_last_rv1", 16'(p1_rvalid), 16'h1);
    chk("rr_last_data", 16'(p1_rdata), 16'h0C0);

    // Port 1 alone, back-to-back reads
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'(k), 8'h00);
      chk("b2b_gnt1", 16'(p1_gnt), 16'h1);
      if (k > 0) begin
        chk("b2b_rv1", 16'(p1_rvalid), 16'h1);
        chk("b2b_data", 16'(p1_rdata), 16'h0C0 + 16'(k - 1));
      end
    end
    idle();
    chk("b2b_rv1_end", 16'(p1_rvalid), 16'h1);
    chk("b2b_data_end", 16'(p1_rdata), 16'h0C3);
    idle();
    chk("b2b_rv1_off", 16'(p1_rvalid), 16'h0);

    // Port 0 granted last, then p0 write contends with p1 read
    drive(1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    chk("cw_pre_gnt0", 16'(p0_gnt), 16'h1);
    drive(1'b1, 1'b1, 9'h020, 8'h3C, 1'b1, 1'b0, 9'h001, 8'h00);
    chk("cw_gnt1", 16'(p1_gnt), 16'h1);
    chk("cw_gnt0_lo", 16'(p0_gnt), 16'h0);
    chk("cw_wen0", 16'(sram_wen), 16'h0);
    chk("cw_raddr", 16'(sram_raddr), 16'h001);
    drive(1'b1, 1'b1, 9'h020, 8'h3C, 1'b1, 1'b0, 9'h001, 8'h00);
    chk("cw_gnt0", 16'(p0_gnt), 16'h1);
    chk("cw_gnt1_lo", 16'(p1_gnt), 16'h0);
    chk("cw_wen1", 16'(sram_wen), 16'h1);
    chk("cw_waddr", 16'(sram_waddr), 16'h020);
    chk("cw_rv1", 16'(p1_rvalid), 16'h1);
    chk("cw_rdata", 16'(p1_rdata), 16'h0C1);
    drive(1'b1, 1'b0, 9'h020, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    chk("cw_rv1_off", 16'(p1_rvalid), 16'h0);
    chk("cw_rv0_wr", 16'(p0_rvalid), 16'h0);
    idle();
    chk("wbr_rv0", 16'(p0_rvalid), 16'h1);
    chk("wbr_data", 16'(p0_rdata), 16'h03C);

    // Reset lands while a port 1 read is in flight
    drive(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h002, 8'h00);
    chk("mr_gnt1", 16'(p1_gnt), 16'h1);
    idle();
    chk("mr_rv1_pre", 16'(p1_rvalid), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_rv1_async", 16'(p1_rvalid), 16'h0);
    drive(1'b1, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h002, 8'h00);
    chk("mr_rv1_hold", 16'(p1_rvalid), 16'h0);
    chk("mr_gnt1_rst", 16'(p1_gnt), 16'h0);
    chk("mr_wen_rst", 16'(sram_wen), 16'h0);
    idle();
    rst_n = 1'b1;
    idle();
    chk("mr_rv1_after", 16'(p1_rvalid), 16'h0);
    drive(1'b1, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h002, 8'h00);
    chk("mr_tie_gnt0", 16'(p0_gnt), 16'h1);
    chk("mr_tie_gnt1", 16'(p1_gnt), 16'h0);

`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    idle();
    pulse_reset();
    #1;
    chk("st_reset", conflicts, 16'h0000);
    for (int k = 0; k < 10; k++)
      drive(1'b1, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h001, 8'h00);
    idle();
    chk("st_ten", conflicts, 16'd10);
    for (int k = 0; k < 70000; k++)
      drive(1'b1, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h001, 8'h00);
    idle();
    chk("st_sat", conflicts, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
